// File: rtl/hash_probe_scheduler.sv
// Round-robin lanes onto one linear-probe hash table; first-probe hit completes 3 cycles after grant, +2 per extra probe.
// Lanes hold ReqValid/ReqKey until their ReqReady pulse; defining PROBE_STATS_EN adds the MaxProbeLen output.
module hash_probe_scheduler #(
  parameter int NUM_PROCESSOR    = 3,
  parameter int DATA_INDEX_WIDTH = 32,
  parameter int BIT_ON_TAILS     = 7,
  parameter int COUNT_WIDTH      = 16,
  localparam int PW = (NUM_PROCESSOR > 1) ? $clog2(NUM_PROCESSOR) : 1
) (
  input  logic                                      Clk,
  input  logic                                      Reset,
  input  logic [NUM_PROCESSOR-1:0]                  ReqValid,
  input  logic [NUM_PROCESSOR*DATA_INDEX_WIDTH-1:0] ReqKey,
  output logic [NUM_PROCESSOR-1:0]                  ReqReady,
  output logic [BIT_ON_TAILS-1:0]                   TabAddr,
  output logic                                      TabRdEn,
  input  logic                                      TabRdUsed,
  input  logic [DATA_INDEX_WIDTH-1:0]               TabRdKey,
  input  logic [COUNT_WIDTH-1:0]                    TabRdCount,
  output logic                                      TabWrEn,
  output logic [DATA_INDEX_WIDTH-1:0]               TabWrKey,
  output logic [COUNT_WIDTH-1:0]                    TabWrCount,
  output logic                                      DoneValid,
  output logic [PW-1:0]                             DoneProc,
  output logic [BIT_ON_TAILS-1:0]                   DoneIndex,
  output logic                                      DoneFull,
  output logic                                      Busy
`ifdef PROBE_STATS_EN
  ,
  output logic [BIT_ON_TAILS:0]                     MaxProbeLen
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FULL  = 3'd4;

  localparam logic [BIT_ON_TAILS:0] LEN = {1'b1, {BIT_ON_TAILS{1'b0}}};
  localparam logic [PW:0]           NP  = (PW+1)'(NUM_PROCESSOR);

  logic [2:0]                  state_q, state_d;
  logic [PW-1:0]               ptr_q, ptr_d;
  logic [PW-1:0]               proc_q, proc_d;
  logic [DATA_INDEX_WIDTH-1:0] key_q, key_d;
  logic [BIT_ON_TAILS-1:0]     idx_q, idx_d;
  logic [BIT_ON_TAILS-1:0]     start_q, start_d;
  logic [BIT_ON_TAILS:0]       probes_q, probes_d;
  logic [COUNT_WIDTH-1:0]      wcnt_q, wcnt_d;

  logic                        gnt_vld;
  logic [PW-1:0]               gnt_idx;
  logic [PW:0]                 cand;
  logic [NUM_PROCESSOR-1:0]    gnt_hot;
  logic [DATA_INDEX_WIDTH-1:0] gnt_key;

  // Cyclic search starting at the round-robin pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_PROCESSOR; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= NP) cand = cand - NP;
      if (!gnt_vld && ReqValid[cand[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
    gnt_hot = '0;
    gnt_key = '0;
    for (int i = 0; i < NUM_PROCESSOR; i++) begin
      if (gnt_vld && gnt_idx == PW'(i)) begin
        gnt_hot[i] = 1'b1;
        gnt_key    = ReqKey[i*DATA_INDEX_WIDTH +: DATA_INDEX_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    proc_d   = proc_q;
    key_d    = key_q;
    idx_d    = idx_q;
    start_d  = start_q;
    probes_d = probes_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          proc_d   = gnt_idx;
          key_d    = gnt_key;
          idx_d    = gnt_key[BIT_ON_TAILS-1:0];
          start_d  = gnt_key[BIT_ON_TAILS-1:0];
          probes_d = (BIT_ON_TAILS+1)'(1);
          ptr_d    = ({1'b0, gnt_idx} == NP - 1'b1) ? '0 : gnt_idx + 1'b1;
          state_d  = S_READ;
        end
      end
      S_READ: state_d = S_CMP;
      S_CMP: begin
        if (!TabRdUsed) begin
          wcnt_d  = COUNT_WIDTH'(1);
          state_d = S_WRITE;
        end else if (TabRdKey == key_q) begin
          wcnt_d  = (&TabRdCount) ? TabRdCount : TabRdCount + 1'b1;
          state_d = S_WRITE;
        end else if (probes_q == LEN) begin
          state_d = S_FULL;
        end else begin
          idx_d    = idx_q + 1'b1;
          probes_d = probes_q + 1'b1;
          state_d  = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      proc_q   <= '0;
      key_q    <= '0;
      idx_q    <= '0;
      start_q  <= '0;
      probes_q <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      proc_q   <= proc_d;
      key_q    <= key_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      probes_q <= probes_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Outputs are forced low while Reset is held so an aborted lookup never writes.
  always_comb begin
    ReqReady   = '0;
    TabAddr    = '0;
    TabRdEn    = 1'b0;
    TabWrEn    = 1'b0;
    TabWrKey   = '0;
    TabWrCount = '0;
    DoneValid  = 1'b0;
    DoneProc   = '0;
    DoneIndex  = '0;
    DoneFull   = 1'b0;
    Busy       = 1'b0;
    if (!Reset) begin
      Busy = (state_q != S_IDLE);
      case (state_q)
        S_IDLE: ReqReady = gnt_hot;
        S_READ: begin
          TabRdEn = 1'b1;
          TabAddr = idx_q;
        end
        S_WRITE: begin
          TabWrEn    = 1'b1;
          TabAddr    = idx_q;
          TabWrKey   = key_q;
          TabWrCount = wcnt_q;
          DoneValid  = 1'b1;
          DoneProc   = proc_q;
          DoneIndex  = idx_q;
        end
        S_FULL: begin
          DoneValid = 1'b1;
          DoneFull  = 1'b1;
          DoneProc  = proc_q;
          DoneIndex = start_q;
        end
        default: ;
      endcase
    end
  end

`ifdef PROBE_STATS_EN
  logic [BIT_ON_TAILS:0] max_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      max_q <= '0;
    end else if ((state_q == S_WRITE || state_q == S_FULL) && probes_q > max_q) begin
      max_q <= probes_q;
    end
  end

  assign MaxProbeLen = max_q;
`else
  // Probe-length statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_hash_probe_scheduler.sv
// Bench for hash_probe_scheduler: behavioural table model plus bench-side BRAM, directed cases then random traffic.
module tb_hash_probe_scheduler;
  localparam int NP  = 3;
  localparam int W   = 32;
  localparam int BT  = 7;
  localparam int CW  = 16;
  localparam int LEN = 128;
  localparam int PW  = 2;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [NP-1:0]     ReqValid = '0;
  logic [NP*W-1:0]   ReqKey = '0;
  logic [NP-1:0]     ReqReady;
  logic [BT-1:0]     TabAddr;
  logic              TabRdEn;
  logic              TabRdUsed = 1'b0;
  logic [W-1:0]      TabRdKey = '0;
  logic [CW-1:0]     TabRdCount = '0;
  logic              TabWrEn;
  logic [W-1:0]      TabWrKey;
  logic [CW-1:0]     TabWrCount;
  logic              DoneValid;
  logic [PW-1:0]     DoneProc;
  logic [BT-1:0]     DoneIndex;
  logic              DoneFull;
  logic              Busy;
`ifdef PROBE_STATS_EN
  logic [BT:0]       MaxProbeLen;
`endif

  hash_probe_scheduler dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqKey(ReqKey), .ReqReady(ReqReady),
    .TabAddr(TabAddr), .TabRdEn(TabRdEn), .TabRdUsed(TabRdUsed), .TabRdKey(TabRdKey),
    .TabRdCount(TabRdCount), .TabWrEn(TabWrEn), .TabWrKey(TabWrKey), .TabWrCount(TabWrCount),
    .DoneValid(DoneValid), .DoneProc(DoneProc), .DoneIndex(DoneIndex), .DoneFull(DoneFull),
    .Busy(Busy)
`ifdef PROBE_STATS_EN
    , .MaxProbeLen(MaxProbeLen)
`endif
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mode    = 0;   // 0: drop after grant, 1: hold continuously, 2: random traffic

  // Bench-side table storage (what the DUT actually wrote) and the model's table.
  bit            mem_used[LEN];
  logic [W-1:0]  mem_key[LEN];
  logic [CW-1:0] mem_cnt[LEN];
  bit            ref_used[LEN];
  logic [W-1:0]  ref_key[LEN];
  logic [CW-1:0] ref_cnt[LEN];

  // Model state of the lookup in flight.
  bit            active = 1'b0;
  int            m_ptr = 0, m_grant_c = 0, m_proc = 0, m_start = 0, m_probes = 0, m_slot = 0, m_max = 0;
  bit            m_full = 1'b0;
  logic [W-1:0]  m_key = '0;
  logic [CW-1:0] m_cnt = '0;

  // Observations of the DUT, used by the literal checks.
  logic [NP-1:0] got = '0;
  int            grants_n = 0, done_cnt = 0, dut_grant_c = 0, rd_cnt = 0, first_rd_addr = 0;
  int            last_grant = 0, last_lat = 0, last_reads = 0, last_idx = 0, last_proc = 0;
  bit            last_full = 1'b0, last_wr = 1'b0;
  logic [W-1:0]  last_wr_key = '0;
  logic [CW-1:0] last_wr_cnt = '0;
  int            gq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Linear probe from key mod LEN: first free slot inserts, matching key increments (saturating), else full.
  function automatic void model_lookup(input logic [W-1:0] k, output int probes, output bit full,
                                       output int slot, output logic [CW-1:0] cnt);
    int  s0;
    bit  found;
    s0 = int'(k % LEN);
    found = 1'b0;
    full = 1'b1; probes = LEN; slot = s0; cnt = '0;
    for (int p = 0; p < LEN; p++) begin
      int s;
      s = (s0 + p) % LEN;
      if (!found && !ref_used[s]) begin
        found = 1'b1; full = 1'b0; probes = p + 1; slot = s; cnt = 1;
      end else if (!found && ref_key[s] == k) begin
        found = 1'b1; full = 1'b0; probes = p + 1; slot = s;
        cnt = (ref_cnt[s] == 16'hFFFF) ? ref_cnt[s] : ref_cnt[s] + 16'd1;
      end
    end
  endfunction

  task automatic cycle_check();
    logic [NP-1:0] e_rr;
    bit e_rd, e_wr, e_done, e_busy;
    int e_addr, off, gj;
    cyc++;
    if (ReqReady != 0) begin
      grants_n++; dut_grant_c = cyc; rd_cnt = 0;
      for (int i = 0; i < NP; i++) if (ReqReady[i]) last_grant = i;
      gq.push_back(last_grant);
    end
    if (TabRdEn) begin
      if (rd_cnt == 0) first_rd_addr = TabAddr;
      rd_cnt++;
      TabRdUsed  = mem_used[TabAddr];
      TabRdKey   = mem_key[TabAddr];
      TabRdCount = mem_cnt[TabAddr];
    end
    if (TabWrEn) begin
      mem_used[TabAddr] = 1'b1;
      mem_key[TabAddr]  = TabWrKey;
      mem_cnt[TabAddr]  = TabWrCount;
    end
    if (DoneValid) begin
      done_cnt++; last_lat = cyc - dut_grant_c; last_reads = rd_cnt; last_idx = DoneIndex;
      last_proc = DoneProc; last_full = DoneFull; last_wr = TabWrEn;
      last_wr_key = TabWrKey; last_wr_cnt = TabWrCount;
    end
    if (Reset) begin
      chk("rst_ReqReady", ReqReady, 0);
      chk("rst_Busy", Busy, 0);
      chk("rst_TabRdEn", TabRdEn, 0);
      chk("rst_TabWrEn", TabWrEn, 0);
      chk("rst_DoneValid", DoneValid, 0);
      chk("rst_DoneFull", DoneFull, 0);
      chk("rst_TabAddr", TabAddr, 0);
      active = 1'b0; m_ptr = 0; m_max = 0; got = '0;
      return;
    end
    e_rr = '0; e_rd = 0; e_wr = 0; e_done = 0; e_busy = 0; e_addr = 0; gj = 0;
    if (active) begin
      e_busy = 1'b1;
      off = cyc - m_grant_c;
      if (off % 2 == 1 && off < 2 * m_probes) begin
        e_rd = 1'b1; e_addr = (m_start + (off - 1) / 2) % LEN;
      end
      if (off == 2 * m_probes + 1) begin
        e_done = 1'b1; e_wr = !m_full; e_addr = m_slot;
      end
    end else begin
      for (int k = 0; k < NP; k++) begin
        int j;
        j = (m_ptr + k) % NP;
        if (e_rr == 0 && ReqValid[j]) begin e_rr[j] = 1'b1; gj = j; end
      end
    end
    chk("ReqReady", ReqReady, e_rr);
    chk("Busy", Busy, e_busy);
    chk("TabRdEn", TabRdEn, e_rd);
    chk("TabWrEn", TabWrEn, e_wr);
    chk("DoneValid", DoneValid, e_done);
    chk("RdWrExclusive", TabRdEn & TabWrEn, 0);
    if (e_rd || e_wr) chk("TabAddr", TabAddr, e_addr);
    if (e_wr) begin
      chk("TabWrKey", TabWrKey, m_key);
      chk("TabWrCount", TabWrCount, m_cnt);
    end
    if (e_done) begin
      chk("DoneProc", DoneProc, m_proc);
      chk("DoneFull", DoneFull, m_full);
      chk("DoneIndex", DoneIndex, m_full ? m_start : m_slot);
    end
`ifdef PROBE_STATS_EN
    chk("MaxProbeLen", MaxProbeLen, m_max);
`endif
    if (e_done) begin
      if (!m_full) begin
        ref_used[m_slot] = 1'b1; ref_key[m_slot] = m_key; ref_cnt[m_slot] = m_cnt;
      end
      if (m_probes > m_max) m_max = m_probes;
      active = 1'b0;
    end else if (e_rr != 0) begin
      active = 1'b1; m_grant_c = cyc; m_proc = gj;
      m_key = ReqKey[gj*W +: W];
      m_start = int'(m_key % LEN);
      model_lookup(m_key, m_probes, m_full, m_slot, m_cnt);
      m_ptr = (gj + 1) % NP;
    end
    got = ReqReady;
  endtask

  function automatic logic [W-1:0] rnd_key();
    if ($urandom_range(0, 9) == 0) return 32'(100 + $urandom_range(0, 3));
    return 32'($urandom_range(0, 3)) * 128 + 32'($urandom_range(0, 23));
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (got[i]) begin
        if (mode == 0) ReqValid[i] = 1'b0;
        else if (mode == 2) begin
          ReqValid[i] = 1'($urandom_range(0, 1));
          ReqKey[i*W +: W] = rnd_key();
        end
      end else if (mode == 2 && !ReqValid[i] && $urandom_range(0, 3) == 0) begin
        ReqValid[i] = 1'b1;
        ReqKey[i*W +: W] = rnd_key();
      end
    end
  endtask

  task automatic step();
    @(negedge Clk);
    cycle_check();
    @(posedge Clk);
    #1;
    drive();
  endtask

  task automatic clear_table();
    for (int s = 0; s < LEN; s++) begin
      mem_used[s] = 1'b0; mem_key[s] = '0; mem_cnt[s] = '0;
      ref_used[s] = 1'b0; ref_key[s] = '0; ref_cnt[s] = '0;
    end
  endtask

  task automatic preload(input int s, input logic [W-1:0] k, input logic [CW-1:0] c);
    mem_used[s] = 1'b1; mem_key[s] = k; mem_cnt[s] = c;
    ref_used[s] = 1'b1; ref_key[s] = k; ref_cnt[s] = c;
  endtask

  task automatic wait_done(input int budget);
    int n0, b;
    n0 = done_cnt; b = 0;
    while (done_cnt == n0 && b < budget) begin step(); b++; end
    chk("done_timeout", 64'(done_cnt != n0), 1);
  endtask

  task automatic request(input int lane, input logic [W-1:0] k, input int budget);
    ReqValid[lane] = 1'b1;
    ReqKey[lane*W +: W] = k;
    wait_done(budget);
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while ((ReqValid != 0 || Busy) && b < budget) begin step(); b++; end
    chk("drain_timeout", 64'(ReqValid == 0 && !Busy), 1);
  endtask

  initial begin
    int g0, n0, b;
    clear_table();
    repeat (3) step();
    Reset = 1'b0;

    // Empty table, first-probe insert.
    request(0, 32'h85, 20);
    chk("t1_rdaddr", first_rd_addr, 5);
    chk("t1_idx", last_idx, 5);
    chk("t1_wrkey", last_wr_key, 32'h85);
    chk("t1_cnt", last_wr_cnt, 1);
    chk("t1_lat", last_lat, 3);
    chk("t1_proc", last_proc, 0);

    // One collision then free slot.
    clear_table();
    preload(5, 32'h05, 16'd3);
    request(0, 32'h85, 20);
    chk("t2_idx", last_idx, 6);
    chk("t2_reads", last_reads, 2);
    chk("t2_lat", last_lat, 5);

    // Probe wraps from the last slot to slot 0.
    clear_table();
    preload(127, 32'h17F, 16'd7);
    request(0, 32'hFF, 20);
    chk("t3_rdaddr", first_rd_addr, 127);
    chk("t3_idx", last_idx, 0);
    chk("t3_lat", last_lat, 5);

    // Fairness from reset and count saturation.
    Reset = 1'b1; step(); step(); Reset = 1'b0;
    clear_table();
    preload(3, 32'h03, 16'hFFFF);
    gq.delete();
    mode = 1;
    ReqValid = '1;
    for (int i = 0; i < NP; i++) ReqKey[i*W +: W] = 32'h03;
    b = 0;
    while (gq.size() < 4 && b < 100) begin step(); b++; end
    ReqValid = '0; mode = 0;
    chk("t4_grants", 64'(gq.size() >= 4), 1);
    if (gq.size() >= 4) begin
      chk("t4_g0", gq[0], 0);
      chk("t4_g1", gq[1], 1);
      chk("t4_g2", gq[2], 2);
      chk("t4_g3", gq[3], 0);
    end
    wait_done(20);
    chk("t4_satcnt", last_wr_cnt, 16'hFFFF);

    // Full table, no match anywhere.
    clear_table();
    for (int s = 0; s < LEN; s++) preload(s, 32'h1000 + 32'(s), 16'd1);
    request(1, 32'h10, 400);
    chk("t5_full", last_full, 1);
    chk("t5_nowrite", last_wr, 0);
    chk("t5_reads", last_reads, 128);
    chk("t5_lat", last_lat, 257);
    chk("t5_idx", last_idx, 32'h10);
`ifdef PROBE_STATS_EN
    chk("t5_maxprobe", MaxProbeLen, 128);
`endif

    // Reset during compare aborts the lookup.
    clear_table();
    g0 = grants_n;
    ReqValid[2] = 1'b1; ReqKey[2*W +: W] = 32'h22;
    b = 0;
    while (grants_n == g0 && b < 10) begin step(); b++; end
    chk("t6_granted", grants_n - g0, 1);
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    ReqValid = '1;
    for (int i = 0; i < NP; i++) ReqKey[i*W +: W] = 32'h40 + 32'(i);
    g0 = grants_n; n0 = done_cnt;
    step();
    chk("t6_one_grant", grants_n - g0, 1);
    chk("t6_grant_p0", last_grant, 0);
    chk("t6_no_done", done_cnt - n0, 0);
    drain(100);
    chk("t6_slot_untouched", mem_used[32'h22], 0);

    // Random traffic with clustered keys and near-saturated counters.
    Reset = 1'b1; step(); Reset = 1'b0;
    clear_table();
    for (int s = 100; s < 104; s++) preload(s, 32'(s), 16'hFFFE);
    mode = 2;
    repeat (4000) step();
    mode = 0;
    drain(3000);
    for (int s = 0; s < LEN; s++)
      chk("table_slot", {15'd0, mem_used[s], mem_key[s], mem_cnt[s]},
          {15'd0, ref_used[s], ref_key[s], ref_cnt[s]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
